max10_feeder: RTL and testbench
===============================

# max10_feeder

Serial-to-parallel frame packer that sits directly upstream of the 10-input maximum unit. It accepts one 32-bit score per cycle from the classifier output stream and assembles each group of ten into a parallel vector. It presents that vector with a single-cycle valid pulse, matching the max unit's `input_valid` / `d_in_0..d_in_9` interface. Short frames are closed early by `last_in` and padded, so the downstream max always sees ten operands.

## Interface
- `PAD_VALUE`, default `32'h8000_0000`: value written into unfilled slots of a short frame. It must lose every max comparison downstream.
- `CNT_W`, default 16: width of `frame_count`.

- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `input_valid`  in  1  `d_in` / `last_in` carry a word this cycle.
- `d_in`  in  32  score word.
- `last_in`  in  1  word is the final one of its frame; ignored when `input_valid`=0.
- `output_valid`  out  1  one-cycle pulse: `d_out_0..d_out_9` hold a new frame.
- `d_out_0` … `d_out_9`  out  32 each  frame slots; slot n = n-th accepted word of the frame.
- `short_frame`  out  1  sticky: some frame was closed with fewer than 10 words.
- `frame_count`  out  `CNT_W`  number of frames emitted since reset, modulo 2^`CNT_W`.

## Operation
- Internal state:
  - 4-bit slot counter `cnt` (0..9);
  - collection bank `bank[0..9]` (32 b each);
  - registered output bank `d_out_0..9`.
- No backpressure: every cycle with `input_valid`=1 consumes one word.
- Accepted word with `cnt` < 9 and `last_in`=0:
  - `bank[cnt]` <= `d_in`;
  - `cnt` <= `cnt`+1.
- Accepted word with `cnt`=9, or with `last_in`=1 at any `cnt` (frame close):
  - `d_out_k` <= `bank[k]` for k < `cnt`;
  - `d_out_cnt` <= `d_in`;
  - `d_out_k` <= `PAD_VALUE` for k > `cnt`;
  - `output_valid` <= 1;
  - `frame_count` <= `frame_count`+1, wrapping;
  - `cnt` <= 0.
- Short-frame flag: if a frame closes with `cnt` < 9 (only possible via `last_in`), `short_frame` <= 1. It stays set until reset.
- `last_in`=1 at `cnt`=9 is a normal full frame; `short_frame` is unaffected.
- No `last_in` at the 10th word: the frame closes anyway. The 11th word starts a new frame at slot 0.
- Cycles with `input_valid`=0:
  - `cnt` and `bank` hold;
  - `output_valid` <= 0.
- `d_out_*` hold their last emitted frame until the next close.
- `bank` entries above the current fill level are never read. Stale contents are never visible on the outputs.

## Timing
- Reset values, asynchronous:
  - `output_valid`=0, `d_out_0..9`=0, `short_frame`=0, `frame_count`=0;
  - `cnt`=0, `bank`=0.
- Latency: the closing word is accepted on edge k. `output_valid`=1 and the full vector are visible after edge k, for exactly one cycle.
- Back-to-back frames: the first word of the next frame may arrive the cycle right after the closing word. Closes in consecutive cycles (e.g. repeated 1-word `last_in` frames) give `output_valid` high on consecutive cycles, each with the correct vector.
- Minimum spacing between pulses is one cycle. Maximum output rate is one frame per cycle, for 1-word frames.
- Reset asserted mid-frame: the partial frame is discarded, with no pulse. The first word after release goes to slot 0.
- `frame_count` wraps from 2^`CNT_W`−1 to 0 with no other side effect.

## Test plan
- Reset, then 10 consecutive words 1..10 with `last_in` on the 10th:
  - one-cycle `output_valid` after edge 10;
  - `d_out_0`=1 … `d_out_9`=10;
  - `frame_count`=1, `short_frame`=0.
- 3 words `0xA`, `0xB`, `0xC` with `last_in` on the 3rd:
  - `d_out_0..2` = A, B, C;
  - `d_out_3..9` = `0x8000_0000`;
  - `short_frame`=1, sticky through a following full frame.
- 25 words, gaps of random length, no `last_in`:
  - exactly 2 pulses, carrying words 1–10 and 11–20;
  - `d_out` then holds words 11–20 while words 21–25 sit pending;
  - `frame_count`=2.
- Four 1-word `last_in` frames on consecutive cycles: four consecutive `output_valid` cycles, with `d_out_0` equal to each word in turn.
- Assert `rst` after 6 words of a frame, release, then send 10 words 100..109: no pulse for the partial frame; the next vector is 100..109.
- With `CNT_W`=4, send 17 full frames: `frame_count` reads 0 after frame 16 and 1 after frame 17.

Source files
------------

// File: rtl/max10_feeder.sv
// max10_feeder: packs a stream of 32-bit scores into ten-slot frames for the
// downstream 10-input max unit. A frame closes on its tenth word or early on
// last_in; unfilled slots of a short frame carry PAD_VALUE.
module max10_feeder #(
    parameter logic [31:0] PAD_VALUE = 32'h8000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    input  logic [31:0]      d_in,
    input  logic             last_in,
    output logic             output_valid,
    output logic [31:0]      d_out_0,
    output logic [31:0]      d_out_1,
    output logic [31:0]      d_out_2,
    output logic [31:0]      d_out_3,
    output logic [31:0]      d_out_4,
    output logic [31:0]      d_out_5,
    output logic [31:0]      d_out_6,
    output logic [31:0]      d_out_7,
    output logic [31:0]      d_out_8,
    output logic [31:0]      d_out_9,
    output logic             short_frame,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned SLOTS     = 10;
    localparam logic [3:0]  LAST_SLOT = 4'd9;

    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      bank_q [SLOTS];
    logic [31:0]      bank_d [SLOTS];
    logic [31:0]      dout_q [SLOTS];
    logic [31:0]      dout_d [SLOTS];
    logic             valid_q, valid_d;
    logic             short_q, short_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             close;

    // Next-state: collect words into the bank, or on close assemble the output
    // vector from bank, the closing word and padding in a single step.
    always_comb begin
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        short_d = short_q;
        fcnt_d  = fcnt_q;
        close   = input_valid && (last_in || (cnt_q == LAST_SLOT));

        if (close) begin
            // Bank entries at or above cnt_q may be stale from an earlier
            // frame; they are replaced by d_in or padding, never forwarded.
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (k < 32'(cnt_q)) begin
                    dout_d[k[3:0]] = bank_q[k[3:0]];
                end else if (k == 32'(cnt_q)) begin
                    dout_d[k[3:0]] = d_in;
                end else begin
                    dout_d[k[3:0]] = PAD_VALUE;
                end
            end
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + CNT_W'(1);
            cnt_d   = '0;
            if (cnt_q != LAST_SLOT) begin
                short_d = 1'b1;
            end
        end else if (input_valid) begin
            bank_d[cnt_q] = d_in;
            cnt_d         = cnt_q + 4'd1;
        end
    end

    // State registers with asynchronous reset; a mid-frame reset discards
    // the partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            fcnt_q  <= '0;
            for (int unsigned k = 0; k < SLOTS; k++) begin
                bank_q[k[3:0]] <= '0;
                dout_q[k[3:0]] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            short_q <= short_d;
            fcnt_q  <= fcnt_d;
            for (int unsigned k = 0; k < SLOTS; k++) begin
                bank_q[k[3:0]] <= bank_d[k[3:0]];
                dout_q[k[3:0]] <= dout_d[k[3:0]];
            end
        end
    end

    assign output_valid = valid_q;
    assign short_frame  = short_q;
    assign frame_count  = fcnt_q;
    assign d_out_0      = dout_q[0];
    assign d_out_1      = dout_q[1];
    assign d_out_2      = dout_q[2];
    assign d_out_3      = dout_q[3];
    assign d_out_4      = dout_q[4];
    assign d_out_5      = dout_q[5];
    assign d_out_6      = dout_q[6];
    assign d_out_7      = dout_q[7];
    assign d_out_8      = dout_q[8];
    assign d_out_9      = dout_q[9];

endmodule

// File: tb/tb_max10_feeder.sv
// Directed bench for max10_feeder: a vector table for single-cycle behaviour
// plus hand sequences for gapped input, mid-frame reset and counter wrap.
module tb_max10_feeder;

    localparam logic [31:0] PAD = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic        last;

    logic        ov, sh;
    logic [15:0] fc;
    logic [31:0] q [10];

    logic        ov4, sh4;
    logic [3:0]  fc4;
    logic [31:0] q4 [10];

    int total = 0;
    int bad   = 0;
    int pulses;
    logic [9:0][31:0] plog [$];

    typedef struct packed {
        logic             iv;
        logic             last;
        logic [31:0]      d;
        logic             exp_ov;
        logic             exp_sh;
        logic [15:0]      exp_fc;
        logic [9:0][31:0] exp_out;
    } vec_t;

    vec_t tbl [$];

    max10_feeder #(.PAD_VALUE(PAD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .input_valid(iv), .d_in(d), .last_in(last),
        .output_valid(ov),
        .d_out_0(q[0]), .d_out_1(q[1]), .d_out_2(q[2]), .d_out_3(q[3]), .d_out_4(q[4]),
        .d_out_5(q[5]), .d_out_6(q[6]), .d_out_7(q[7]), .d_out_8(q[8]), .d_out_9(q[9]),
        .short_frame(sh), .frame_count(fc)
    );

    max10_feeder #(.PAD_VALUE(PAD), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .input_valid(iv), .d_in(d), .last_in(last),
        .output_valid(ov4),
        .d_out_0(q4[0]), .d_out_1(q4[1]), .d_out_2(q4[2]), .d_out_3(q4[3]), .d_out_4(q4[4]),
        .d_out_5(q4[5]), .d_out_6(q4[6]), .d_out_7(q4[7]), .d_out_8(q4[8]), .d_out_9(q4[9]),
        .short_frame(sh4), .frame_count(fc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected frame: n consecutive words starting at base, then padding.
    function automatic logic [9:0][31:0] frm(input logic [31:0] base, input int unsigned n);
        logic [9:0][31:0] r;
        for (int unsigned i = 0; i < 10; i++)
            r[i[3:0]] = (i < n) ? base + i : PAD;
        return r;
    endfunction

    task automatic add(input logic v, input logic [31:0] dd, input logic l, input logic eov,
                       input logic esh, input logic [15:0] efc, input logic [9:0][31:0] eo);
        vec_t e;
        e.iv = v; e.last = l; e.d = dd;
        e.exp_ov = eov; e.exp_sh = esh; e.exp_fc = efc; e.exp_out = eo;
        tbl.push_back(e);
    endtask

    task automatic step(input logic v, input logic [31:0] dd, input logic l);
        logic [9:0][31:0] cap;
        @(negedge clk);
        iv = v; d = dd; last = l;
        @(posedge clk);
        #1;
        if (ov) begin
            pulses++;
            for (int unsigned i = 0; i < 10; i++) cap[i[3:0]] = q[i];
            plog.push_back(cap);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [9:0][31:0] act, input logic [9:0][31:0] exp);
        for (int unsigned i = 0; i < 10; i++)
            chk($sformatf("%s.slot%0d", nm, i), act[i[3:0]], exp[i[3:0]]);
    endtask

    task automatic chk_out(input string nm, input logic [9:0][31:0] exp);
        for (int unsigned i = 0; i < 10; i++)
            chk($sformatf("%s.d_out_%0d", nm, i), q[i], exp[i[3:0]]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0][31:0] zero;
        logic [9:0][31:0] cur;
        zero = '0;

        rst = 1'b1; iv = 1'b0; d = '0; last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.output_valid", {31'b0, ov}, 32'd0);
        chk("reset.short_frame", {31'b0, sh}, 32'd0);
        chk("reset.frame_count", {16'b0, fc}, 32'd0);
        chk_out("reset", zero);
        @(negedge clk);
        rst = 1'b0;

        // Full frame 1..10 closed by last_in on the tenth word
        for (int unsigned i = 1; i <= 9; i++) add(1'b1, i, 1'b0, 1'b0, 1'b0, 16'd0, zero);
        add(1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 16'd1, frm(32'd1, 10));
        add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd1, frm(32'd1, 10));
        // Short frame A,B,C
        add(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 16'd1, frm(32'd1, 10));
        add(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 16'd1, frm(32'd1, 10));
        add(1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 16'd2, frm(32'hA, 3));
        // Full frame without last_in: short_frame must stay set
        for (int unsigned i = 0; i < 9; i++)
            add(1'b1, 32'h20 + i, 1'b0, 1'b0, 1'b1, 16'd2, frm(32'hA, 3));
        add(1'b1, 32'h29, 1'b0, 1'b1, 1'b1, 16'd3, frm(32'h20, 10));
        // Four back-to-back one-word frames
        for (int unsigned j = 0; j < 4; j++)
            add(1'b1, 32'h51 + j, 1'b1, 1'b1, 1'b1, 16'(4 + j), frm(32'h51 + j, 1));
        // last_in without input_valid is ignored
        add(1'b0, 32'h77, 1'b1, 1'b0, 1'b1, 16'd7, frm(32'h54, 1));
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd7, frm(32'h54, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            iv = tbl[i].iv; d = tbl[i].d; last = tbl[i].last;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.output_valid", i), {31'b0, ov}, {31'b0, tbl[i].exp_ov});
            chk($sformatf("tbl%0d.short_frame", i), {31'b0, sh}, {31'b0, tbl[i].exp_sh});
            chk($sformatf("tbl%0d.frame_count", i), {16'b0, fc}, {16'b0, tbl[i].exp_fc});
            chk_out($sformatf("tbl%0d", i), tbl[i].exp_out);
        end

        // 25 words with random gaps, no last_in
        pulses = 0;
        plog.delete();
        for (int unsigned w = 1; w <= 25; w++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 32'd0, 1'b0);
            step(1'b1, 32'h100 + w, 1'b0);
        end
        step(1'b0, 32'd0, 1'b0);
        chk("gap.pulses", pulses, 32'd2);
        if (plog.size() >= 1) chk_vec("gap.frame1", plog[0], frm(32'h101, 10));
        if (plog.size() >= 2) chk_vec("gap.frame2", plog[1], frm(32'h10B, 10));
        chk_out("gap.hold", frm(32'h10B, 10));
        chk("gap.frame_count", {16'b0, fc}, 32'd9);
        chk("gap.short_frame", {31'b0, sh}, 32'd1);

        // Sixth word of the pending frame, then an asynchronous reset
        step(1'b1, 32'h1FF, 1'b0);
        @(negedge clk);
        iv = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst.frame_count", {16'b0, fc}, 32'd0);
        chk("async_rst.short_frame", {31'b0, sh}, 32'd0);
        chk("async_rst.d_out_0", q[0], 32'd0);
        chk("async_rst.d_out_9", q[9], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        plog.delete();
        for (int unsigned i = 0; i < 10; i++) step(1'b1, 32'd100 + i, 1'b0);
        chk("post_rst.output_valid", {31'b0, ov}, 32'd1);
        step(1'b0, 32'd0, 1'b0);
        chk("post_rst.pulse_width", {31'b0, ov}, 32'd0);
        chk("post_rst.pulses", pulses, 32'd1);
        if (plog.size() >= 1) chk_vec("post_rst.frame", plog[0], frm(32'd100, 10));
        chk("post_rst.frame_count", {16'b0, fc}, 32'd1);
        chk("post_rst.short_frame", {31'b0, sh}, 32'd0);

        // frame_count wrap on the CNT_W=4 instance
        pulse_reset();
        for (int unsigned f = 1; f <= 17; f++) begin
            for (int unsigned i = 0; i < 10; i++) step(1'b1, (f << 8) + i, 1'b0);
            if (f == 16) begin
                chk("wrap16.frame_count4", {28'b0, fc4}, 32'd0);
                chk("wrap16.frame_count16", {16'b0, fc}, 32'd16);
                chk("wrap16.output_valid4", {31'b0, ov4}, 32'd1);
            end
            if (f == 17) begin
                chk("wrap17.frame_count4", {28'b0, fc4}, 32'd1);
                chk("wrap17.frame_count16", {16'b0, fc}, 32'd17);
                chk("wrap17.short_frame4", {31'b0, sh4}, 32'd0);
                cur = frm((32'd17 << 8), 10);
                chk("wrap17.d_out_9", q4[9], cur[9]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
